// File: rtl/parse_act_pkg.sv
// Shared definitions for the parser action-RAM configuration loader:
// module ID, beat count, FSM states and header field offsets.
`timescale 1ns/1ps
package parse_act_pkg;

    localparam logic [7:0] MODULE_ID_PARSE_ACT = 8'h01;
    localparam int         BEAT_BITS           = 64;
    localparam int         ENTRY_BITS_DEF      = 160;
    localparam int         NBEATS              = (ENTRY_BITS_DEF + BEAT_BITS - 1) / BEAT_BITS;

    localparam int MOD_ID_LSB = 0;
    localparam int IDX_LSB    = 8;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        WRITE,
        DRAIN
    } state_t;

endpackage

// File: rtl/parse_act_cfg_loader.sv
// Receives control packets over AXI-Stream, assembles one parse-action entry
// and issues a single-cycle write into the action RAM at the header's index.
`timescale 1ns/1ps
module parse_act_cfg_loader
    import parse_act_pkg::*;
#(
    parameter int         C_S_AXIS_DATA_WIDTH = 64,
    parameter int         ADDR_BITS           = 5,
    parameter int         DATA_BITS           = 160,
    parameter logic [7:0] MODULE_ID           = MODULE_ID_PARSE_ACT
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [7:0]                     s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [ADDR_BITS-1:0]           ram_addra,
    output logic [DATA_BITS-1:0]           ram_dina,
    output logic                           ram_ena,
    output logic                           ram_wea,
    output logic [15:0]                    cfg_wr_cnt,
    output logic [15:0]                    cfg_err_cnt
);

    localparam int NB    = (DATA_BITS + C_S_AXIS_DATA_WIDTH - 1) / C_S_AXIS_DATA_WIDTH;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic                   end_seen_q, end_seen_d;
    logic [DATA_BITS-1:0]   entry_q, entry_d;
    logic                   tready_q, tready_d;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   dina_q, dina_d;
    logic [15:0]            wr_cnt_q, wr_cnt_d;
    logic [15:0]            err_cnt_q, err_cnt_d;

    logic                   accept;
    logic [NB-1:0]          slot_sel;
    logic [DATA_BITS-1:0]   slot_next;
    logic                   tkeep_unused;

    assign tkeep_unused = ^s_axis_tkeep;
    assign accept       = s_axis_tvalid && tready_q;

    // Entry with the current beat merged into slot beat_cnt; the last slot is
    // narrower when DATA_BITS is not a multiple of the beat width.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_slot
            localparam int LO = gi * C_S_AXIS_DATA_WIDTH;
            localparam int W  = (DATA_BITS - LO > C_S_AXIS_DATA_WIDTH) ?
                                C_S_AXIS_DATA_WIDTH : (DATA_BITS - LO);
            assign slot_sel[gi]       = (beat_cnt_q == CNT_W'(gi));
            assign slot_next[LO +: W] = slot_sel[gi] ? s_axis_tdata[W-1:0] : entry_q[LO +: W];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        idx_d      = idx_q;
        end_seen_d = end_seen_q;
        entry_d    = entry_q;
        err_cnt_d  = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_axis_tlast) begin
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    end else if (s_axis_tdata[MOD_ID_LSB +: 8] != MODULE_ID) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d      = s_axis_tdata[IDX_LSB +: ADDR_BITS];
                        beat_cnt_d = '0;
                        state_d    = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    entry_d = slot_next;
                    if (beat_cnt_q == CNT_W'(NB - 1)) begin
                        end_seen_d = s_axis_tlast;
                        state_d    = WRITE;
                    end else if (s_axis_tlast) begin
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        entry_d = '0;
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                state_d = end_seen_q ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (accept && s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM-side outputs are registered against the next state so the write
    // strobe lines up exactly with the WRITE cycle.
    always_comb begin
        tready_d = (state_d != WRITE);
        we_d     = (state_d == WRITE);
        addr_d   = addr_q;
        dina_d   = dina_q;
        wr_cnt_d = wr_cnt_q;
        if (state_d == WRITE) begin
            addr_d = idx_d;
            dina_d = entry_d;
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            idx_q      <= '0;
            end_seen_q <= 1'b0;
            entry_q    <= '0;
            tready_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            dina_q     <= '0;
            wr_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            idx_q      <= idx_d;
            end_seen_q <= end_seen_d;
            entry_q    <= entry_d;
            tready_q   <= tready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            dina_q     <= dina_d;
            wr_cnt_q   <= wr_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign ram_ena       = we_q;
    assign ram_wea       = we_q;
    assign ram_addra     = addr_q;
    assign ram_dina      = dina_q;
    assign cfg_wr_cnt    = wr_cnt_q;
    assign cfg_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parse_act_cfg_loader.sv
// Directed bench for the parse-action configuration loader.
`timescale 1ns/1ps
module tb_parse_act_cfg_loader;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [63:0]   s_axis_tdata;
    logic [7:0]    s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [4:0]    ram_addra;
    logic [159:0]  ram_dina;
    logic          ram_ena;
    logic          ram_wea;
    logic [15:0]   cfg_wr_cnt;
    logic [15:0]   cfg_err_cnt;

    int compared   = 0;
    int mismatched = 0;

    parse_act_cfg_loader #(
        .C_S_AXIS_DATA_WIDTH(64),
        .ADDR_BITS(5),
        .DATA_BITS(160),
        .MODULE_ID(8'h01)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .ram_addra(ram_addra),
        .ram_dina(ram_dina),
        .ram_ena(ram_ena),
        .ram_wea(ram_wea),
        .cfg_wr_cnt(cfg_wr_cnt),
        .cfg_err_cnt(cfg_err_cnt)
    );

    always #5 clk = ~clk;

    // Write monitor: records every strobed write and every not-ready cycle.
    int           wr_cycles = 0;
    int           nrdy      = 0;
    logic [4:0]   cap_addr [16];
    logic [159:0] cap_data [16];
    logic         cap_ena  [16];

    always @(negedge clk) begin
        if (aresetn) begin
            if (ram_wea) begin
                if (wr_cycles < 16) begin
                    cap_addr[wr_cycles] = ram_addra;
                    cap_data[wr_cycles] = ram_dina;
                    cap_ena[wr_cycles]  = ram_ena;
                end
                wr_cycles++;
            end
            if (!s_axis_tready) nrdy++;
        end
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] id, input logic [4:0] idx);
        return {48'hA5A5_0000_5A5A, 3'b111, idx, id};
    endfunction

    // Presents one beat and waits (bounded) for it to be accepted.
    task automatic send(input logic [63:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("beat_accept", {159'd0, ok}, 160'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [159:0] exp_e;
    int           wr0, nr0;

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = 8'hFF;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", {159'd0, s_axis_tready}, 160'd0);
        check("rst_wea",    {159'd0, ram_wea},       160'd0);
        check("rst_ena",    {159'd0, ram_ena},       160'd0);
        check("rst_addra",  {155'd0, ram_addra},     160'd0);
        check("rst_dina",   ram_dina,                160'd0);
        check("rst_wrcnt",  {144'd0, cfg_wr_cnt},    160'd0);
        check("rst_errcnt", {144'd0, cfg_err_cnt},   160'd0);
        aresetn = 1'b1;
        idle(1);
        check("post_rst_tready", {159'd0, s_axis_tready}, 160'd1);
        idle(2);

        // Test 1: valid packet to index 5; last beat's upper half dropped
        wr0 = wr_cycles; nr0 = nrdy;
        send(hdr(8'h01, 5'd5), 1'b0);
        send(64'h1111_1111_1111_1111, 1'b0);
        send(64'h2222_2222_2222_2222, 1'b0);
        send(64'h0000_0000_3333_3333, 1'b1);
        exp_e = {32'h3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        check("t1_wea_now",   {159'd0, ram_wea},       160'd1);
        check("t1_ena_now",   {159'd0, ram_ena},       160'd1);
        check("t1_tready_lo", {159'd0, s_axis_tready}, 160'd0);
        check("t1_addra",     {155'd0, ram_addra},     160'd5);
        check("t1_dina",      ram_dina,                exp_e);
        check("t1_wrcnt",     {144'd0, cfg_wr_cnt},    160'd1);
        idle(1);
        check("t1_wea_drop",  {159'd0, ram_wea},       160'd0);
        check("t1_tready_hi", {159'd0, s_axis_tready}, 160'd1);
        idle(3);
        check("t1_nwrites",   160'(wr_cycles - wr0),   160'd1);
        check("t1_nrdy",      160'(nrdy - nr0),        160'd1);

        // Test 2: foreign module ID is sunk silently
        wr0 = wr_cycles;
        send(hdr(8'h02, 5'd7), 1'b0);
        send(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        send(64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
        send(64'hCCCC_CCCC_CCCC_CCCC, 1'b1);
        idle(3);
        check("t2_nwrites", 160'(wr_cycles - wr0),  160'd0);
        check("t2_wrcnt",   {144'd0, cfg_wr_cnt},   160'd1);
        check("t2_errcnt",  {144'd0, cfg_err_cnt},  160'd0);
        check("t2_dina_hold", ram_dina,             exp_e);

        // Test 3: short packet, then a valid one
        wr0 = wr_cycles;
        send(hdr(8'h01, 5'd3), 1'b0);
        send(64'h0101_0101_0101_0101, 1'b0);
        send(64'h0202_0202_0202_0202, 1'b1);
        idle(2);
        check("t3_short_nwrites", 160'(wr_cycles - wr0), 160'd0);
        check("t3_errcnt",        {144'd0, cfg_err_cnt}, 160'd1);
        send(hdr(8'h01, 5'd9), 1'b0);
        send(64'h0123_4567_89AB_CDEF, 1'b0);
        send(64'hFEDC_BA98_7654_3210, 1'b0);
        send(64'hDEAD_BEEF_4444_4444, 1'b1);
        idle(3);
        check("t3_nwrites", 160'(wr_cycles - wr0), 160'd1);
        check("t3_addra",   {155'd0, cap_addr[wr0]}, 160'd9);
        check("t3_dina",    cap_data[wr0],
              {32'h4444_4444, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
        check("t3_ena",     {159'd0, cap_ena[wr0]},  160'd1);

        // Test 4: header-only packet, then a 6-beat packet with 2 extra beats
        send(hdr(8'h01, 5'd2), 1'b1);
        idle(1);
        check("t4_errcnt_hdr", {144'd0, cfg_err_cnt}, 160'd2);
        wr0 = wr_cycles;
        send(hdr(8'h01, 5'd12), 1'b0);
        send(64'h5555_5555_5555_5555, 1'b0);
        send(64'h6666_6666_6666_6666, 1'b0);
        send(64'h7777_7777_7777_7777, 1'b0);
        send(64'h8888_8888_8888_8888, 1'b0);
        send(64'h9999_9999_9999_9999, 1'b1);
        idle(3);
        check("t4_nwrites", 160'(wr_cycles - wr0),  160'd1);
        check("t4_addra",   {155'd0, cap_addr[wr0]}, 160'd12);
        check("t4_dina",    cap_data[wr0],
              {32'h7777_7777, 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        check("t4_errcnt",  {144'd0, cfg_err_cnt},  160'd2);
        // A header-only packet now must count as an error, proving IDLE
        send(hdr(8'h01, 5'd1), 1'b1);
        idle(1);
        check("t4_idle_after_drain", {144'd0, cfg_err_cnt}, 160'd3);

        // Test 5: valid gaps and back-to-back packets to indices 0 and 31
        wr0 = wr_cycles;
        send(hdr(8'h01, 5'd0), 1'b0);
        idle($urandom_range(0, 3));
        send(64'h0A0A_0A0A_0A0A_0A0A, 1'b0);
        idle($urandom_range(1, 3));
        send(64'h0B0B_0B0B_0B0B_0B0B, 1'b0);
        idle($urandom_range(0, 3));
        send(64'hFFFF_FFFF_0C0C_0C0C, 1'b1);
        send(hdr(8'h01, 5'd31), 1'b0);
        send(64'h1D1D_1D1D_1D1D_1D1D, 1'b0);
        idle($urandom_range(1, 3));
        send(64'h1E1E_1E1E_1E1E_1E1E, 1'b0);
        idle($urandom_range(0, 3));
        send(64'h0000_0000_1F1F_1F1F, 1'b1);
        idle(3);
        check("t5_nwrites", 160'(wr_cycles - wr0),      160'd2);
        check("t5_addr0",   {155'd0, cap_addr[wr0]},     160'd0);
        check("t5_data0",   cap_data[wr0],
              {32'h0C0C_0C0C, 64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A});
        check("t5_addr31",  {155'd0, cap_addr[wr0 + 1]}, 160'd31);
        check("t5_data31",  cap_data[wr0 + 1],
              {32'h1F1F_1F1F, 64'h1E1E_1E1E_1E1E_1E1E, 64'h1D1D_1D1D_1D1D_1D1D});
        check("t5_wrcnt",   {144'd0, cfg_wr_cnt},        160'd5);
        check("t5_errcnt",  {144'd0, cfg_err_cnt},       160'd3);

        // Test 6: reset mid-packet, then a fresh packet and error saturation
        wr0 = wr_cycles;
        send(hdr(8'h01, 5'd20), 1'b0);
        send(64'h2121_2121_2121_2121, 1'b0);
        send(64'h2222_2222_2222_2222, 1'b0);
        aresetn = 1'b0;
        #1;
        check("t6_rst_tready", {159'd0, s_axis_tready}, 160'd0);
        check("t6_rst_wea",    {159'd0, ram_wea},       160'd0);
        check("t6_rst_addra",  {155'd0, ram_addra},     160'd0);
        check("t6_rst_dina",   ram_dina,                160'd0);
        check("t6_rst_wrcnt",  {144'd0, cfg_wr_cnt},    160'd0);
        check("t6_rst_errcnt", {144'd0, cfg_err_cnt},   160'd0);
        idle(2);
        aresetn = 1'b1;
        idle(1);
        check("t6_post_tready", {159'd0, s_axis_tready}, 160'd1);
        idle(3);
        check("t6_no_write", 160'(wr_cycles - wr0), 160'd0);
        send(hdr(8'h01, 5'd17), 1'b0);
        send(64'h3131_3131_3131_3131, 1'b0);
        send(64'h3232_3232_3232_3232, 1'b0);
        send(64'h7777_7777_3333_3333, 1'b1);
        idle(3);
        check("t6_nwrites", 160'(wr_cycles - wr0),  160'd1);
        check("t6_addra",   {155'd0, cap_addr[wr0]}, 160'd17);
        check("t6_dina",    cap_data[wr0],
              {32'h3333_3333, 64'h3232_3232_3232_3232, 64'h3131_3131_3131_3131});
        check("t6_wrcnt",   {144'd0, cfg_wr_cnt},    160'd1);

        // Stream header-only packets, one per cycle, into the error counter
        s_axis_tdata  = hdr(8'h01, 5'd4);
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_errcnt_fffe", {144'd0, cfg_err_cnt}, 160'hFFFE);
        repeat (6) @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("sat_errcnt_ffff", {144'd0, cfg_err_cnt}, 160'hFFFF);
        idle(2);
        check("sat_errcnt_hold", {144'd0, cfg_err_cnt}, 160'hFFFF);
        check("sat_wrcnt",       {144'd0, cfg_wr_cnt},  160'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/parse_act_cfg_loader.md
Name: parse_act_cfg_loader

Overview:
- Control-path stage directly upstream of the parser action RAM.
- Consumes control packets on an AXI-Stream slave and checks the module ID.
- Assembles one DATA_BITS-wide parse-action entry and drives a single-cycle write into the RAM's write port (addra/dina/ena/wea) at the packet's index.
- Sinks packets addressed to other modules. Counts completed writes and malformed packets.

Parameters:
- C_S_AXIS_DATA_WIDTH, 64: control stream beat width. Only 64 is supported.
- ADDR_BITS, 5: RAM index width. Must be ≤ 8.
- DATA_BITS, 160: entry width.
- NBEATS, derived = ceil(DATA_BITS/64), i.e. 3: payload beats per entry.
- MODULE_ID, 8'h01: ID this loader accepts.

Ports:
- clk  in  1  sole clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  64  control beat
- s_axis_tkeep  in  8  ignored; all bytes treated valid
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  loader accepts beat
- ram_addra  out  ADDR_BITS  write index
- ram_dina  out  DATA_BITS  entry data
- ram_ena  out  1  write-port enable
- ram_wea  out  1  write enable
- cfg_wr_cnt  out  16  entries written, saturating
- cfg_err_cnt  out  16  short packets, saturating

Behaviour:
- Clocking/reset:
  - One clock (clk). Reset aresetn is asynchronous, active-low.
  - On reset: state=IDLE, s_axis_tready=0 during reset and 1 in the first cycle after release, ram_ena=ram_wea=0, ram_addra=0, ram_dina=0, both counters=0, beat counter=0.
- Beat accept: a beat is accepted when s_axis_tvalid && s_axis_tready.
- Header beat (first beat of a packet):
  - [7:0] module_id
  - [8+ADDR_BITS-1:8] index
  - remaining bits reserved, ignored
- Payload:
  - Payload beat k (k=0..NBEATS-1) fills entry bits [64k+63:64k], least-significant beat first.
  - Bits of the last beat beyond DATA_BITS are dropped.
- s_axis_tready = 1 in every state except WRITE, where it is 0.
- State IDLE (accepted beat):
  - tlast=1 → cfg_err_cnt++, stay IDLE, no write.
  - module_id != MODULE_ID → DRAIN. Not an error.
  - else latch index, beat_cnt=0 → PAYLOAD.
- State PAYLOAD (accepted beat):
  - Store beat at slot beat_cnt.
  - If beat_cnt == NBEATS-1: set end_seen=tlast → WRITE.
  - Else if tlast: cfg_err_cnt++, discard partial entry → IDLE.
  - Else beat_cnt++.
- State WRITE (exactly one cycle):
  - ram_ena=ram_wea=1, ram_addra=latched index, ram_dina=assembled entry. cfg_wr_cnt++.
  - Next state: IDLE if end_seen, else DRAIN.
  - ram_ena/ram_wea are registered and high only in this cycle. Latency: one cycle after the final payload beat is accepted.
- State DRAIN: accept and discard beats. tlast → IDLE.
- Valid gaps: tvalid low in any state causes no transition; the partial entry is held.
- Back-to-back packets: a header arriving in the cycle after WRITE (IDLE) is accepted normally. No beat is lost, because tready=0 during WRITE.
- Saturation: counters stop at 16'hFFFF and never wrap.
- Extra payload beats beyond NBEATS are drained without error.
- Reset mid-packet: the partial entry is discarded with no RAM write. The next accepted beat is treated as a header.
- ram_dina holds its last written value between writes. Writes are qualified by ram_wea only.

Decomposition:
- Shared package (parse_act_pkg) holds:
  - constants MODULE_ID_PARSE_ACT and NBEATS
  - state enum {IDLE, PAYLOAD, WRITE, DRAIN}
  - header field offsets (MOD_ID_LSB=0, IDX_LSB=8)
- No sub-module. The beat-to-entry assembly register is inline.

Test Plan:
- Valid packet, id 0x01, index 5, payload beats 0x1111…, 0x2222…, 0x0000_0000_3333_3333 → exactly one cycle with ram_wea=1, ram_addra=5, ram_dina={32'h3333_3333, 64'h2222…, 64'h1111…}; cfg_wr_cnt=1; tready low only in that cycle.
- Packet with module_id 0x02, 4 beats → no ram_wea, counters unchanged, all beats accepted.
- Short packet, header plus 2 beats with tlast on the 2nd → no write, cfg_err_cnt=1. Next valid packet writes correctly.
- Header-only packet (tlast on header) → cfg_err_cnt increments, no write. 6-beat valid packet → one write, then beats 5–6 drained, state returns to IDLE.
- Random tvalid gaps plus back-to-back valid packets to indices 0 and 31 → two writes with correct data. Indices 0 and 31 (full-scale wrap of ADDR_BITS) are exercised.
- aresetn asserted after the second payload beat → all outputs zero immediately; after release, no write occurs and a fresh packet writes normally. cfg_err_cnt forced near 0xFFFF stays at 0xFFFF.
